// File: rtl/demod_pkg.sv
// Shared constants, state encoding and fixed-point helper for the FM polar discriminator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demod_pkg;

    localparam int QUANT_BITS = 10;
    localparam int QUANT_VAL  = 1 << QUANT_BITS;

    // Quantized pi/4 and 3*pi/4 at 10 fractional bits.
    localparam int QUAD1 = 804;
    localparam int QUAD3 = 2412;

    // Working width for every product that gets dequantized.
    localparam int DQ_W = 64;

    typedef enum logic [2:0] {
        S_READ,
        S_MULT,
        S_PREP,
        S_DIV,
        S_ANGLE,
        S_GAIN,
        S_WRITE
    } state_t;

    // Divide by 2^bits truncating toward zero: negative values are biased by
    // (2^bits - 1) before the arithmetic shift so that DQ(-a) == -DQ(a).
    function automatic logic signed [DQ_W-1:0] dequantize(
        input logic signed [DQ_W-1:0] v,
        input int                     bits
    );
        logic signed [DQ_W-1:0] bias;
        bias = v[DQ_W-1] ? ((DQ_W'(1) <<< bits) - DQ_W'(1)) : DQ_W'(0);
        return (v + bias) >>> bits;
    endfunction

endpackage

// File: rtl/div_signed.sv
// Iterative restoring divider: signed dividend / positive divisor, quotient truncated toward zero.
// Latency: fixed STEPS cycles; the first quotient bit is resolved on the start edge, done pulses when the quotient is valid.
// Backpressure: none; a new start restarts the divide, quotient holds until the next start.
// Ports: clk, rst (sync active-low), start, dividend[NUM_W], divisor[DEN_W] (must be > 0),
//        quotient[NUM_W] (valid from done until next start), done (1-cycle pulse).
module div_signed #(
    parameter int NUM_W = 43,
    parameter int DEN_W = 33,
    parameter int STEPS = 42
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [NUM_W-1:0] dividend,
    input  logic        [DEN_W-1:0] divisor,
    output logic signed [NUM_W-1:0] quotient,
    output logic                    done
);
    localparam int CW = $clog2(STEPS + 1);

    logic [STEPS-1:0] quo_q, src_quo, nxt_quo;
    logic [DEN_W-1:0] rem_q, den_q, src_rem, src_den, nxt_rem;
    logic [DEN_W:0]   trial, diff;
    logic [NUM_W-1:0] mag_full;
    logic             neg_q, ge;
    logic [CW-1:0]    cnt_q;
    logic signed [NUM_W-1:0] q_mag;
    logic             unused_bits;

    // One restoring step. On start the step runs on the freshly loaded
    // operands so the full divide takes exactly STEPS clock edges.
    always_comb begin
        mag_full = dividend[NUM_W-1] ? -dividend : dividend;
        src_quo  = start ? mag_full[STEPS-1:0] : quo_q;
        src_rem  = start ? '0 : rem_q;
        src_den  = start ? divisor : den_q;
        trial    = {src_rem, src_quo[STEPS-1]};
        diff     = trial - {1'b0, src_den};
        ge       = (trial >= {1'b0, src_den});
        nxt_rem  = ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
        nxt_quo  = {src_quo[STEPS-2:0], ge};
    end

    // Magnitudes never exceed STEPS bits for the operand ranges this block sees.
    assign unused_bits = ^{mag_full[NUM_W-1:STEPS], diff[DEN_W]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            quo_q <= nxt_quo;
            rem_q <= nxt_rem;
            den_q <= divisor;
            neg_q <= dividend[NUM_W-1];
            cnt_q <= CW'(STEPS - 1);
            done  <= (STEPS == 1);
        end else if (cnt_q != '0) begin
            quo_q <= nxt_quo;
            rem_q <= nxt_rem;
            cnt_q <= cnt_q - 1'b1;
            done  <= (cnt_q == CW'(1));
        end else begin
            done  <= 1'b0;
        end
    end

    assign q_mag    = NUM_W'(quo_q);
    assign quotient = neg_q ? -q_mag : q_mag;

endmodule

// File: rtl/fm_demod.sv
// FM polar discriminator: angle of cur*conj(prev) via quantized arctan, scaled by the demod gain.
// Latency: write strobe DATA_WIDTH+BITS+5 cycles after the read strobe; one sample per DATA_WIDTH+BITS+6 cycles.
// Backpressure: holds the result with wr_en low while demod_full; no input is read until the write completes.
// Ports: clk, rst (sync active-low); x_real_in/x_imag_in FWFT heads with *_empty and *_rd_en (always pop together);
//        demod_out/demod_wr_en push into the output FIFO, gated by demod_full.
module fm_demod
    import demod_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = QUANT_BITS,
    parameter int GAIN       = 758
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] x_real_in,
    input  logic signed [DATA_WIDTH-1:0] x_imag_in,
    input  logic                         x_real_empty,
    input  logic                         x_imag_empty,
    output logic                         x_real_rd_en,
    output logic                         x_imag_rd_en,
    output logic signed [DATA_WIDTH-1:0] demod_out,
    output logic                         demod_wr_en,
    input  logic                         demod_full
);
    localparam int NUM_W = DATA_WIDTH + BITS + 1;
    localparam int DEN_W = DATA_WIDTH + 1;

    state_t state, state_nxt;
    logic   take, put, div_done;

    logic signed [DATA_WIDTH-1:0] prev_r, prev_i, cur_r, cur_i, mix_r, mix_i, angle;
    logic signed [DQ_W-1:0]       p_rr, p_ii, p_ri, p_ir;
    logic signed [DEN_W-1:0]      r_ext, i_ext, abs_y, diff;
    logic        [DEN_W-1:0]      den;
    logic signed [NUM_W-1:0]      num, quo;
    logic signed [DQ_W-1:0]       quad, ang_full, gain_full;

    // cur * conj(prev) cross products at double width.
    always_comb begin
        p_rr = DQ_W'(prev_r) * DQ_W'(cur_r);
        p_ii = DQ_W'(prev_i) * DQ_W'(cur_i);
        p_ri = DQ_W'(prev_r) * DQ_W'(cur_i);
        p_ir = DQ_W'(prev_i) * DQ_W'(cur_r);
    end

    // Ratio setup for the arctan approximation; abs_y carries +1 so the
    // denominator can never be zero.
    always_comb begin
        r_ext = DEN_W'(mix_r);
        i_ext = DEN_W'(mix_i);
        abs_y = ((i_ext < 0) ? -i_ext : i_ext) + DEN_W'(1);
        if (!mix_r[DATA_WIDTH-1]) begin
            diff = r_ext - abs_y;
            den  = r_ext + abs_y;
        end else begin
            diff = r_ext + abs_y;
            den  = abs_y - r_ext;
        end
        num = NUM_W'(diff) <<< BITS;
    end

    // Quadrant follows the sign of the held real part; the sign of the
    // imaginary part mirrors the angle into the lower half plane.
    always_comb begin
        quad     = mix_r[DATA_WIDTH-1] ? DQ_W'(QUAD3) : DQ_W'(QUAD1);
        ang_full = quad - dequantize(DQ_W'(QUAD1) * DQ_W'(quo), BITS);
        if (mix_i[DATA_WIDTH-1]) begin
            ang_full = -ang_full;
        end
        gain_full = dequantize(DQ_W'(GAIN) * DQ_W'(angle), BITS);
    end

    div_signed #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .STEPS (DATA_WIDTH + BITS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (state == S_PREP),
        .dividend (num),
        .divisor  (den),
        .quotient (quo),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_READ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        put       = 1'b0;
        case (state)
            S_READ: begin
                if (!x_real_empty && !x_imag_empty) begin
                    take      = 1'b1;
                    state_nxt = S_MULT;
                end
            end
            S_MULT:  state_nxt = S_PREP;
            S_PREP:  state_nxt = S_DIV;
            S_DIV:   if (div_done) state_nxt = S_ANGLE;
            S_ANGLE: state_nxt = S_GAIN;
            S_GAIN:  state_nxt = S_WRITE;
            S_WRITE: begin
                if (!demod_full) begin
                    put       = 1'b1;
                    state_nxt = S_READ;
                end
            end
            default: state_nxt = S_READ;
        endcase
    end

    // Strobes are forced low while reset is held.
    assign x_real_rd_en = rst & take;
    assign x_imag_rd_en = rst & take;
    assign demod_wr_en  = rst & put;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_r    <= '0;
            prev_i    <= '0;
            cur_r     <= '0;
            cur_i     <= '0;
            mix_r     <= '0;
            mix_i     <= '0;
            angle     <= '0;
            demod_out <= '0;
        end else begin
            if (take) begin
                cur_r <= x_real_in;
                cur_i <= x_imag_in;
            end
            if (state == S_MULT) begin
                mix_r  <= DATA_WIDTH'(dequantize(p_rr, BITS) + dequantize(p_ii, BITS));
                mix_i  <= DATA_WIDTH'(dequantize(p_ri, BITS) - dequantize(p_ir, BITS));
                prev_r <= cur_r;
                prev_i <= cur_i;
            end
            if (state == S_ANGLE) begin
                angle <= DATA_WIDTH'(ang_full);
            end
            if (state == S_GAIN) begin
                demod_out <= DATA_WIDTH'(gain_full);
            end
        end
    end

endmodule

// File: tb/tb_fm_demod.sv
module tb_fm_demod;
    localparam int DW      = 32;
    localparam int TIMEOUT = 300;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] x_real_in, x_imag_in, demod_out;
    logic                 x_real_empty, x_imag_empty;
    logic                 x_real_rd_en, x_imag_rd_en;
    logic                 demod_wr_en, demod_full;

    int     checks = 0;
    int     errors = 0;
    longint prev_r, prev_i;

    always #5 clk = ~clk;

    fm_demod #(.DATA_WIDTH(DW), .BITS(10), .GAIN(758)) dut (
        .clk          (clk),
        .rst          (rst),
        .x_real_in    (x_real_in),
        .x_imag_in    (x_imag_in),
        .x_real_empty (x_real_empty),
        .x_imag_empty (x_imag_empty),
        .x_real_rd_en (x_real_rd_en),
        .x_imag_rd_en (x_imag_rd_en),
        .demod_out    (demod_out),
        .demod_wr_en  (demod_wr_en),
        .demod_full   (demod_full)
    );

    // Reference: the discriminator written directly as integer arithmetic.
    function automatic int ref_demod(longint pr, longint pim, longint cr, longint ci);
        longint r, im, ay, num, den, q, base, ang;
        r  = (pr * cr) / 1024 + (pim * ci) / 1024;
        im = (pr * ci) / 1024 - (pim * cr) / 1024;
        ay = ((im < 0) ? -im : im) + 1;
        if (r >= 0) begin
            num = (r - ay) * 1024; den = r + ay; base = 804;
        end else begin
            num = (r + ay) * 1024; den = ay - r; base = 2412;
        end
        q   = num / den;
        ang = base - (804 * q) / 1024;
        if (im < 0) ang = -ang;
        return int'((758 * ang) / 1024);
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Offers one sample, waits for it to be popped, then waits for the write.
    // lat counts cycles from the read cycle to the write cycle (-1 on timeout).
    task automatic send_sample(input int cr, input int ci, output int lat,
                               output logic signed [DW-1:0] val, output int wait_rd);
        @(negedge clk);
        x_real_in = cr; x_imag_in = ci;
        x_real_empty = 1'b0; x_imag_empty = 1'b0;
        #1;
        wait_rd = 0;
        while (!(x_real_rd_en && x_imag_rd_en) && wait_rd < TIMEOUT) begin
            @(negedge clk); #1; wait_rd++;
        end
        @(negedge clk);
        x_real_empty = 1'b1; x_imag_empty = 1'b1;
        #1;
        lat = 1;
        while (!demod_wr_en && lat < TIMEOUT) begin
            @(negedge clk); #1; lat++;
        end
        if (!demod_wr_en) lat = -1;
        val = demod_out;
    endtask

    task automatic test_reset();
        rst = 1'b0; demod_full = 1'b0;
        x_real_in = '0; x_imag_in = '0;
        x_real_empty = 1'b1; x_imag_empty = 1'b1;
        repeat (3) @(negedge clk);
        x_real_empty = 1'b0; x_imag_empty = 1'b0;
        #1;
        checks++;
        if (x_real_rd_en !== 1'b0 || x_imag_rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_rd_en: got %b%b expected 00", x_real_rd_en, x_imag_rd_en);
        end
        checks++;
        if (demod_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en: got %b expected 0", demod_wr_en);
        end
        checks++;
        if (demod_out !== '0) begin
            errors++; $display("FAIL reset_demod_out: got %0d expected 0", demod_out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (x_real_rd_en !== 1'b1 || x_imag_rd_en !== 1'b1) begin
            errors++; $display("FAIL idle_read: got %b%b expected 11", x_real_rd_en, x_imag_rd_en);
        end
        x_real_empty = 1'b1; x_imag_empty = 1'b1;
        #1;
        checks++;
        if (x_real_rd_en !== 1'b0 || x_imag_rd_en !== 1'b0) begin
            errors++; $display("FAIL empty_gate: got %b%b expected 00", x_real_rd_en, x_imag_rd_en);
        end
        prev_r = 0; prev_i = 0;
    endtask

    task automatic test_directed();
        int lat, w;
        logic signed [DW-1:0] val, exp;
        int cr [6] = '{0, 1024, 1024, 0, 1024, -1024};
        int ci [6] = '{0, 0, 0, -1024, 0, 0};
        // Known results where the angle is analytically fixed; model otherwise.
        int fixed_exp [6] = '{1190, 0, 1, -1190, 0, 2379};
        bit fixed     [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            exp = fixed[k] ? DW'(fixed_exp[k]) : DW'(ref_demod(prev_r, prev_i, cr[k], ci[k]));
            send_sample(cr[k], ci[k], lat, val, w);
            checks++;
            if (val !== exp) begin
                errors++; $display("FAIL directed_%0d: got %0d expected %0d", k, val, exp);
            end
            checks++;
            if (lat !== 47) begin
                errors++; $display("FAIL latency_%0d: got %0d expected 47", k, lat);
            end
            prev_r = cr[k]; prev_i = ci[k];
        end
    endtask

    task automatic test_one_empty();
        int cnt;
        for (int side = 0; side < 2; side++) begin
            @(negedge clk);
            x_real_in = 77; x_imag_in = -77;
            x_real_empty = (side == 1); x_imag_empty = (side == 0);
            cnt = 0;
            repeat (20) begin
                #1;
                if (x_real_rd_en || x_imag_rd_en) cnt++;
                @(negedge clk);
            end
            x_real_empty = 1'b1; x_imag_empty = 1'b1;
            checks++;
            if (cnt !== 0) begin
                errors++; $display("FAIL one_empty_%0d: got %0d read cycles expected 0", side, cnt);
            end
        end
    endtask

    task automatic test_full_hold();
        logic signed [DW-1:0] exp_a, exp_b, held, val;
        int ar, ai, br, bi, n, rd_cnt, wr_cnt, chg, lat;
        ar = rnd(); ai = rnd(); br = rnd(); bi = rnd();
        exp_a = DW'(ref_demod(prev_r, prev_i, ar, ai));
        exp_b = DW'(ref_demod(ar, ai, br, bi));
        held = '0;
        @(negedge clk);
        demod_full = 1'b1;
        x_real_in = ar; x_imag_in = ai;
        x_real_empty = 1'b0; x_imag_empty = 1'b0;
        #1;
        n = 0;
        while (!(x_real_rd_en && x_imag_rd_en) && n < TIMEOUT) begin
            @(negedge clk); #1; n++;
        end
        // Second sample sits at the FIFO heads for the whole stall.
        @(negedge clk);
        x_real_in = br; x_imag_in = bi;
        #1;
        rd_cnt = 0; wr_cnt = 0; chg = 0;
        for (int k = 1; k <= 147; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            if (x_real_rd_en || x_imag_rd_en) rd_cnt++;
            if (demod_wr_en) wr_cnt++;
            if (k == 47) held = demod_out;
            if (k > 47 && demod_out !== held) chg++;
        end
        checks++;
        if (held !== exp_a) begin
            errors++; $display("FAIL full_value: got %0d expected %0d", held, exp_a);
        end
        checks++;
        if (wr_cnt !== 0 || rd_cnt !== 0) begin
            errors++; $display("FAIL full_strobes: got wr=%0d rd=%0d expected 0 0", wr_cnt, rd_cnt);
        end
        checks++;
        if (chg !== 0) begin
            errors++; $display("FAIL full_stable: got %0d changes expected 0", chg);
        end
        @(negedge clk);
        demod_full = 1'b0;
        #1;
        checks++;
        if (demod_wr_en !== 1'b1 || x_real_rd_en !== 1'b0) begin
            errors++; $display("FAIL release_write: got wr=%b rd=%b expected 1 0", demod_wr_en, x_real_rd_en);
        end
        @(negedge clk); #1;
        checks++;
        if (x_real_rd_en !== 1'b1 || x_imag_rd_en !== 1'b1 || demod_wr_en !== 1'b0) begin
            errors++; $display("FAIL read_after_write: got rd=%b%b wr=%b expected 11 0",
                               x_real_rd_en, x_imag_rd_en, demod_wr_en);
        end
        @(posedge clk); #1;
        x_real_empty = 1'b1; x_imag_empty = 1'b1;
        @(negedge clk); #1;
        lat = 1;
        while (!demod_wr_en && lat < TIMEOUT) begin
            @(negedge clk); #1; lat++;
        end
        val = demod_out;
        checks++;
        if (val !== exp_b || lat !== 47) begin
            errors++; $display("FAIL after_full: got %0d lat %0d expected %0d lat 47", val, lat, exp_b);
        end
        prev_r = br; prev_i = bi;
    endtask

    task automatic test_back_to_back();
        int cr, ci, lat, w;
        logic signed [DW-1:0] val, exp;
        for (int k = 0; k < 10; k++) begin
            cr = rnd(); ci = rnd();
            exp = DW'(ref_demod(prev_r, prev_i, cr, ci));
            send_sample(cr, ci, lat, val, w);
            checks++;
            if (val !== exp) begin
                errors++; $display("FAIL random_%0d: got %0d expected %0d (in %0d,%0d)", k, val, exp, cr, ci);
            end
            checks++;
            if (lat !== 47 || (k > 0 && w !== 0)) begin
                errors++; $display("FAIL b2b_timing_%0d: got lat %0d wait %0d expected 47 0", k, lat, w);
            end
            prev_r = cr; prev_i = ci;
        end
        @(negedge clk); #1;
        checks++;
        if (demod_wr_en !== 1'b0) begin
            errors++; $display("FAIL wr_pulse: got %b expected 0", demod_wr_en);
        end
    endtask

    task automatic test_reset_mid();
        int n, wr_cnt, lat, w;
        logic signed [DW-1:0] val;
        @(negedge clk);
        x_real_in = 1024; x_imag_in = 0;
        x_real_empty = 1'b0; x_imag_empty = 1'b0;
        #1;
        n = 0;
        while (!(x_real_rd_en && x_imag_rd_en) && n < TIMEOUT) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        x_real_empty = 1'b1; x_imag_empty = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (x_real_rd_en !== 1'b0 || x_imag_rd_en !== 1'b0 || demod_wr_en !== 1'b0 || demod_out !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got rd=%b%b wr=%b out=%0d expected 00 0 0",
                               x_real_rd_en, x_imag_rd_en, demod_wr_en, demod_out);
        end
        rst = 1'b1;
        wr_cnt = 0;
        repeat (60) begin
            @(negedge clk); #1;
            if (demod_wr_en) wr_cnt++;
        end
        checks++;
        if (wr_cnt !== 0) begin
            errors++; $display("FAIL mid_reset_no_write: got %0d writes expected 0", wr_cnt);
        end
        prev_r = 0; prev_i = 0;
        send_sample(1024, 0, lat, val, w);
        checks++;
        if (val !== DW'(1190) || lat !== 47) begin
            errors++; $display("FAIL mid_reset_prev: got %0d lat %0d expected 1190 lat 47", val, lat);
        end
        prev_r = 1024; prev_i = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_one_empty();
        test_full_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fm_demod.md
Name: fm_demod

Overview:
- FM polar discriminator that sits directly downstream of fir_cmplx in the FM receive chain.
- Pops one complex baseband sample per transaction from the filter's real/imag output FIFOs and forms cur*conj(prev).
- Computes the quantized arctangent of that product, scales it by the demod gain, and pushes one signed audio-rate sample into an output FIFO.
- Bit-exact with the team's C fixed-point model: truncating integer division, 10-bit quantization.

Parameters:
DATA_WIDTH, 32, width of input samples and output sample
BITS, 10, quantization shift (QUANT_VAL = 2^BITS)
GAIN, 758, quantized demod gain (QUAD_RATE/(2*pi*MAX_DEV) * 1024)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
x_real_in  in  DATA_WIDTH  signed real sample (FIFO head, first-word-fall-through)
x_imag_in  in  DATA_WIDTH  signed imag sample
x_real_empty  in  1  real FIFO empty
x_imag_empty  in  1  imag FIFO empty
x_real_rd_en  out  1  pop real FIFO
x_imag_rd_en  out  1  pop imag FIFO
demod_out  out  DATA_WIDTH  signed demodulated sample
demod_wr_en  out  1  push to output FIFO
demod_full  in  1  output FIFO full

Behaviour:
- Reset (rst=0 at posedge): state S_READ; prev_r/prev_i=0; demod_out=0; both rd_en=0; demod_wr_en=0. A reset asserted mid-transaction abandons the sample; the divider is cleared and nothing is written.
- DQ(v) = v/QUANT_VAL, truncating toward zero (so DQ(-a) = -DQ(a)). All divides truncate toward zero.
- S_READ: both rd_en are asserted combinationally, in the same cycle, only when !x_real_empty && !x_imag_empty. The heads are latched as cur_r/cur_i. Both rd_en always assert together; one empty holds both low. -> S_MULT.
- S_MULT: form 2*DATA_WIDTH products.
  - r = DQ(prev_r*cur_r) + DQ(prev_i*cur_i)
  - i = DQ(prev_r*cur_i) - DQ(prev_i*cur_r)
  - Truncate r and i to DATA_WIDTH.
  - prev <= cur.
  - -> S_PREP.
- S_PREP: abs_y = |i| + 1.
  - If r >= 0: num = (r - abs_y) << BITS, den = r + abs_y, quad = QUAD1.
  - Else: num = (r + abs_y) << BITS, den = abs_y - r, quad = QUAD3.
  - num is DATA_WIDTH+BITS+1 bits signed; den is DATA_WIDTH+1 bits, always > 0.
  - Pulse div start. -> S_DIV.
- S_DIV: wait for div done. The divider runs exactly DATA_WIDTH+BITS cycles (one quotient bit per cycle). -> S_ANGLE.
- S_ANGLE: angle = quad - DQ(QUAD1*q); negate if i < 0. -> S_GAIN.
- S_GAIN: demod_out <= DQ(GAIN*angle), truncated to DATA_WIDTH. -> S_WRITE.
- S_WRITE: demod_wr_en=1 only when !demod_full; that cycle -> S_READ.
  - While full, demod_out is held, wr_en stays low and no input is read.
  - Full dropping and empty deasserting in the same cycle: the write completes first; the read happens the next cycle.
- Latency: the first demod_wr_en comes DATA_WIDTH+BITS+5 cycles after the rd_en cycle (47 at defaults) when demod_full is low.
- Throughput: one sample per DATA_WIDTH+BITS+6 cycles.
- Width rules: intermediate overflow beyond DATA_WIDTH is truncated (wraps), matching the C int model.

Decomposition:
- Package demod_pkg holds:
  - QUANT_BITS, QUANT_VAL
  - QUAD1 = 804 (QUANTIZE_F(pi/4))
  - QUAD3 = 2412
  - function dequantize
  - state enum {S_READ, S_MULT, S_PREP, S_DIV, S_ANGLE, S_GAIN, S_WRITE}
- One sub-module, div_signed: iterative restoring divider.
  - Inputs: signed dividend, positive divisor, start.
  - Outputs: quotient truncated toward zero, done pulse.
  - Synchronous active-low reset.
  - Fixed cycle count.

Test Plan:
- After reset, push (0,0) -> prev=0, r=i=0, angle 1608, demod_out=1190, wr_en exactly 47 cycles after rd_en.
- prev=(1024,0), cur=(1024,0) -> q=1022, angle=2, demod_out=1.
- prev=(1024,0), cur=(0,-1024) -> i=-1024, angle=-1608, demod_out=-1190 (trunc toward zero, not -1191).
- prev=(1024,0), cur=(-1024,0) -> r<0 branch, q=-1022, angle=3214, demod_out=2379.
- Hold demod_full=1 for 100 cycles during S_WRITE -> wr_en=0, demod_out stable, no rd_en; release -> one write, then next read.
- Real FIFO non-empty, imag empty -> no rd_en. rst=0 during S_DIV -> all outputs 0, no write, prev=0; the next sample reproduces the first test case (1190).
